cpu_oci_debug_mem_ctrl: RTL and testbench
=========================================

# cpu_oci_debug_mem_ctrl

Consumer of the CPU JTAG debug wrapper's system-clock outputs. It turns the `take_action_ocimem_*` strobes and the `jdo` payload into word reads and writes on the on-chip debug memory. It returns read data and status to the JTAG scan chain through `MonDReg`, `monitor_ready` and `monitor_error`. It sits between the debug wrapper and the debug ROM/RAM port in the CPU's OCI.

## Interface
- `ADDR_W`, default 8: word-address width of the debug memory; the address wraps at 2^ADDR_W.
- `clk`  in  1  system clock; the same clock that drives the wrapper's sysclk side.
- `reset`  in  1  asynchronous, active-high reset.
- `jdo`  in  38  JTAG data-out payload; valid in any cycle where a strobe is high.
- `take_action_ocimem_a`  in  1  one-cycle strobe: address load, optional read.
- `take_action_ocimem_b`  in  1  one-cycle strobe: write data at the current address.
- `take_no_action_ocimem_a`  in  1  one-cycle strobe: read at the current address.
- `mem_addr`  out  ADDR_W  memory word address.
- `mem_rd`  out  1  read request; held until accepted.
- `mem_wr`  out  1  write request; held until accepted.
- `mem_wdata`  out  32  write data.
- `mem_waitrequest`  in  1  memory stall; a request is accepted in a cycle where it is high and this is low.
- `mem_rdata`  in  32  read data; valid exactly one cycle after read acceptance.
- `MonDReg`  out  32  monitor data register (read data or last written data).
- `monitor_ready`  out  1  last command complete.
- `monitor_error`  out  1  sticky: a command was dropped.

## Operation
- Registers:
  - `MonAReg[ADDR_W-1:0]` drives `mem_addr`.
  - `MonDReg[31:0]` drives `mem_wdata` and the `MonDReg` output.
  - `monitor_ready` and `monitor_error`.
  - State register.
- States: IDLE, READ, RDATA, WRITE.
- Commands are decoded only in IDLE. Priority when strobes coincide: `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`.
- `take_action_ocimem_a`:
  - `MonAReg` <= `jdo[ADDR_W+25:26]`.
  - If `jdo[24]`, clear `monitor_error`.
  - If `jdo[35]`, go to READ; otherwise `monitor_ready` <= 1 and stay in IDLE.
- `take_action_ocimem_b`: `MonDReg` <= `jdo[34:3]`, go to WRITE.
- `take_no_action_ocimem_a`: go to READ.
- On any accepted command, `monitor_ready` <= 0. This includes the address-only load, which then sets `monitor_ready` back to 1 the next cycle.
- READ:
  - `mem_rd`=1.
  - On acceptance: `MonAReg` <= `MonAReg`+1 (modulo 2^ADDR_W), go to RDATA.
- RDATA:
  - `MonDReg` <= `mem_rdata`, `monitor_ready` <= 1, go to IDLE.
- WRITE:
  - `mem_wr`=1.
  - On acceptance: `MonAReg`+1, `monitor_ready` <= 1, go to IDLE.
- `mem_rd` and `mem_wr` are decoded from the state register. They are never both high.
- Any strobe outside IDLE is dropped: `monitor_error` <= 1 and the state is unaffected.
- `monitor_error` clears only on reset or on an `ocimem_a` command with `jdo[24]`=1.

## Timing
- Reset values: state=IDLE; `MonAReg`=0; `MonDReg`=0; `monitor_ready`=0; `monitor_error`=0; `mem_rd`=`mem_wr`=0.
- Reset is asynchronous. Asserted mid-transaction, it drops `mem_rd`/`mem_wr` immediately and discards any pending read data.
- Read with no stall: strobe at cycle T; `mem_rd` high at T+1; data captured at the T+2 edge; `monitor_ready`=1 visible from T+3.
- Write with no stall: strobe at T; `mem_wr` high at T+1; `monitor_ready`=1 from T+2.
- Each stall cycle adds one cycle of latency. `mem_addr` and `mem_wdata` stay stable while a request is held.
- Address-only load: `monitor_ready`=0 at T+1, =1 from T+2.
- Wrap-around: an access at address 2^ADDR_W-1 leaves `MonAReg`=0.

## Structure
- Shared package (`cpu_oci_pkg`):
  - State enum.
  - `jdo` field positions: `JDO_RD`=35, `JDO_CLRERR`=24, `JDO_ADDR_LSB`=26, `JDO_WDATA_MSB`=34, `JDO_WDATA_LSB`=3.
- Single module; no sub-module is warranted.

## Test plan
- Load and read:
  - Stimulus: `ocimem_a` with address 0x10 and `jdo[35]`=1; memory returns 0xDEADBEEF.
  - Required: `mem_rd` at T+1 with `mem_addr`=0x10; `MonDReg`=0xDEADBEEF and `monitor_ready`=1 at T+3; `MonAReg`=0x11.
- Write then read-next:
  - Stimulus: `ocimem_b` with `jdo[34:3]`=0x12345678 at address 0x11; then `take_no_action_ocimem_a`.
  - Required: write observed with `mem_wdata`=0x12345678 at address 0x11; the read is issued at address 0x12.
- Stall:
  - Stimulus: `mem_waitrequest` high for 3 cycles during a write.
  - Required: `mem_wr`, `mem_addr` and `mem_wdata` held stable; `monitor_ready` rises 3 cycles later than the no-stall case.
- Busy drop:
  - Stimulus: strobe during READ.
  - Required: `monitor_error`=1; the read completes normally. A subsequent `ocimem_a` with `jdo[24]`=1 clears `monitor_error`.
- Wrap and priority:
  - Stimulus: read at address 0xFF; then assert `ocimem_a` and `ocimem_b` in the same cycle.
  - Required: `MonAReg` becomes 0x00; the load wins and no write is issued.
- Reset mid-read:
  - Stimulus: assert `reset` while `mem_rd`=1.
  - Required: `mem_rd` falls before the next edge; all outputs return to their reset values.

Source files
------------

// File: rtl/cpu_oci_pkg.sv
// Shared definitions for the OCI debug-memory controller.
// Holds the controller state encoding and the jdo payload field positions.
// Imported by the controller and available to anything that builds jdo words.
package cpu_oci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_RDATA = 2'd2,
    ST_WRITE = 2'd3
  } oci_state_t;

  localparam int JDO_W         = 38;
  localparam int JDO_RD        = 35;
  localparam int JDO_CLRERR    = 24;
  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/cpu_oci_debug_mem_ctrl.sv
// Turns JTAG debug-wrapper strobes into word reads/writes on the OCI debug memory.
// Latency: read strobe -> ready 3 cycles, write 2 cycles, address load 2 cycles (+1 per stall).
// Backpressure: requests held while mem_waitrequest is high; strobes arriving while busy are dropped and flagged.
module cpu_oci_debug_mem_ctrl
  import cpu_oci_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  oci_state_t        state, state_nxt;
  logic [ADDR_W-1:0] mon_a_reg, mon_a_nxt;
  logic [31:0]       mon_d_reg, mon_d_nxt;
  logic              ready_reg, ready_nxt;
  logic              error_reg, error_nxt;
  // An address-only load reports not-ready for one cycle, then ready.
  logic              ld_pend, ld_pend_nxt;
  logic              any_strobe;

  // jdo bits not carried by any command field.
  logic              unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // State and data registers; reset discards any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mon_a_reg <= '0;
      mon_d_reg <= '0;
      ready_reg <= 1'b0;
      error_reg <= 1'b0;
      ld_pend   <= 1'b0;
    end else begin
      state     <= state_nxt;
      mon_a_reg <= mon_a_nxt;
      mon_d_reg <= mon_d_nxt;
      ready_reg <= ready_nxt;
      error_reg <= error_nxt;
      ld_pend   <= ld_pend_nxt;
    end
  end

  // Command decode in IDLE, request handshake elsewhere; strobes while busy set the sticky error.
  always_comb begin
    state_nxt   = state;
    mon_a_nxt   = mon_a_reg;
    mon_d_nxt   = mon_d_reg;
    ready_nxt   = ready_reg;
    error_nxt   = error_reg;
    ld_pend_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (ld_pend) ready_nxt = 1'b1;
        if (take_action_ocimem_a) begin
          mon_a_nxt = jdo[JDO_ADDR_LSB + ADDR_W - 1 : JDO_ADDR_LSB];
          ready_nxt = 1'b0;
          if (jdo[JDO_CLRERR]) error_nxt = 1'b0;
          if (jdo[JDO_RD]) state_nxt = ST_READ;
          else             ld_pend_nxt = 1'b1;
        end else if (take_action_ocimem_b) begin
          mon_d_nxt = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          ready_nxt = 1'b0;
          state_nxt = ST_WRITE;
        end else if (take_no_action_ocimem_a) begin
          ready_nxt = 1'b0;
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (any_strobe) error_nxt = 1'b1;
        if (!mem_waitrequest) begin
          mon_a_nxt = mon_a_reg + ADDR_W'(1);
          state_nxt = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (any_strobe) error_nxt = 1'b1;
        mon_d_nxt = mem_rdata;
        ready_nxt = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        if (any_strobe) error_nxt = 1'b1;
        if (!mem_waitrequest) begin
          mon_a_nxt = mon_a_reg + ADDR_W'(1);
          ready_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_rd        = (state == ST_READ);
  assign mem_wr        = (state == ST_WRITE);
  assign mem_addr      = mon_a_reg;
  assign mem_wdata     = mon_d_reg;
  assign MonDReg       = mon_d_reg;
  assign monitor_ready = ready_reg;
  assign monitor_error = error_reg;

endmodule

// File: tb/tb_cpu_oci_debug_mem_ctrl.sv
// Directed bench for the OCI debug-memory controller.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Memory is modelled by driving mem_rdata/mem_waitrequest directly.
module tb_cpu_oci_debug_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_waitrequest;
  logic [31:0] mem_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int checks   = 0;
  int failures = 0;

  cpu_oci_debug_mem_ctrl #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .mem_addr                (mem_addr),
    .mem_rd                  (mem_rd),
    .mem_wr                  (mem_wr),
    .mem_wdata               (mem_wdata),
    .mem_waitrequest         (mem_waitrequest),
    .mem_rdata               (mem_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic rd, input logic clr);
    logic [37:0] v;
    v = '0;
    v[33:26] = addr;
    v[35]    = rd;
    v[24]    = clr;
    return v;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] data);
    logic [37:0] v;
    v = '0;
    v[34:3] = data;
    return v;
  endfunction

  task automatic clr_strobes();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
    chk({pfx, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
    chk({pfx, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    chk({pfx, "_MonDReg"}, MonDReg, 32'd0);
    chk({pfx, "_ready"}, {31'd0, monitor_ready}, 32'd0);
    chk({pfx, "_error"}, {31'd0, monitor_error}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    clr_strobes();
    mem_waitrequest = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Load address 0x10 and read; memory returns DEADBEEF.
    mem_rdata = 32'hDEADBEEF;
    jdo = mk_a(8'h10, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    tick();                                   // T+1
    clr_strobes();
    chk("rd_mem_rd_t1", {31'd0, mem_rd}, 32'd1);
    chk("rd_addr_t1", {24'd0, mem_addr}, 32'h10);
    chk("rd_ready_t1", {31'd0, monitor_ready}, 32'd0);
    tick();                                   // T+2
    chk("rd_mem_rd_t2", {31'd0, mem_rd}, 32'd0);
    chk("rd_ready_t2", {31'd0, monitor_ready}, 32'd0);
    tick();                                   // T+3
    chk("rd_data_t3", MonDReg, 32'hDEADBEEF);
    chk("rd_ready_t3", {31'd0, monitor_ready}, 32'd1);
    chk("rd_addr_inc", {24'd0, mem_addr}, 32'h11);

    // Write 0x12345678 at 0x11, then read at 0x12.
    jdo = mk_b(32'h12345678);
    take_action_ocimem_b = 1'b1;
    tick();                                   // T+1
    clr_strobes();
    chk("wr_mem_wr_t1", {31'd0, mem_wr}, 32'd1);
    chk("wr_mem_rd_t1", {31'd0, mem_rd}, 32'd0);
    chk("wr_addr_t1", {24'd0, mem_addr}, 32'h11);
    chk("wr_wdata_t1", mem_wdata, 32'h12345678);
    chk("wr_ready_t1", {31'd0, monitor_ready}, 32'd0);
    tick();                                   // T+2
    chk("wr_ready_t2", {31'd0, monitor_ready}, 32'd1);
    chk("wr_mem_wr_t2", {31'd0, mem_wr}, 32'd0);
    mem_rdata = 32'hCAFEF00D;
    take_no_action_ocimem_a = 1'b1;
    tick();
    clr_strobes();
    chk("rn_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("rn_addr", {24'd0, mem_addr}, 32'h12);
    tick();
    tick();
    chk("rn_data", MonDReg, 32'hCAFEF00D);
    chk("rn_ready", {31'd0, monitor_ready}, 32'd1);

    // Write at 0x13 stalled for three cycles.
    mem_waitrequest = 1'b1;
    jdo = mk_b(32'hA5A55A5A);
    take_action_ocimem_b = 1'b1;
    tick();                                   // T+1
    clr_strobes();
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("st_mem_wr_%0d", i), {31'd0, mem_wr}, 32'd1);
      chk($sformatf("st_addr_%0d", i), {24'd0, mem_addr}, 32'h13);
      chk($sformatf("st_wdata_%0d", i), mem_wdata, 32'hA5A55A5A);
      chk($sformatf("st_ready_%0d", i), {31'd0, monitor_ready}, 32'd0);
      if (i < 3) tick();
    end
    tick();                                   // T+4
    mem_waitrequest = 1'b0;
    chk("st_mem_wr_4", {31'd0, mem_wr}, 32'd1);
    chk("st_ready_4", {31'd0, monitor_ready}, 32'd0);
    tick();                                   // T+5
    chk("st_ready_5", {31'd0, monitor_ready}, 32'd1);
    chk("st_mem_wr_5", {31'd0, mem_wr}, 32'd0);
    chk("st_addr_5", {24'd0, mem_addr}, 32'h14);

    // Strobe while reading is dropped and flagged; read still completes.
    mem_rdata = 32'h0BADCAFE;
    take_no_action_ocimem_a = 1'b1;
    tick();                                   // T+1, READ
    clr_strobes();
    jdo = mk_b(32'hFFFFFFFF);
    take_action_ocimem_b = 1'b1;
    tick();                                   // T+2
    clr_strobes();
    chk("bz_error", {31'd0, monitor_error}, 32'd1);
    chk("bz_no_wr", {31'd0, mem_wr}, 32'd0);
    tick();                                   // T+3
    chk("bz_data", MonDReg, 32'h0BADCAFE);
    chk("bz_ready", {31'd0, monitor_ready}, 32'd1);
    chk("bz_addr", {24'd0, mem_addr}, 32'h15);
    chk("bz_error_sticky", {31'd0, monitor_error}, 32'd1);

    // Load 0xFF with read and error clear; address wraps to 0.
    mem_rdata = 32'h11223344;
    jdo = mk_a(8'hFF, 1'b1, 1'b1);
    take_action_ocimem_a = 1'b1;
    tick();
    clr_strobes();
    chk("wr_err_clr", {31'd0, monitor_error}, 32'd0);
    chk("wp_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("wp_addr_ff", {24'd0, mem_addr}, 32'hFF);
    tick();
    tick();
    chk("wp_data", MonDReg, 32'h11223344);
    chk("wp_addr_wrap", {24'd0, mem_addr}, 32'h00);

    // ocimem_a and ocimem_b together: address-only load wins.
    jdo = mk_a(8'h42, 1'b0, 1'b0);
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();                                   // T+1
    clr_strobes();
    chk("pr_mem_wr_t1", {31'd0, mem_wr}, 32'd0);
    chk("pr_mem_rd_t1", {31'd0, mem_rd}, 32'd0);
    chk("pr_ready_t1", {31'd0, monitor_ready}, 32'd0);
    chk("pr_addr", {24'd0, mem_addr}, 32'h42);
    chk("pr_dreg", MonDReg, 32'h11223344);
    tick();                                   // T+2
    chk("pr_ready_t2", {31'd0, monitor_ready}, 32'd1);
    chk("pr_mem_wr_t2", {31'd0, mem_wr}, 32'd0);

    // Reset asserted while a stalled read is pending.
    mem_waitrequest = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    tick();
    clr_strobes();
    chk("mr_mem_rd", {31'd0, mem_rd}, 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("mr");
    tick();
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    tick();
    chk_reset_vals("mr_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
